oam_dma_controller: RTL and testbench

//  Sprite OAM DMA engine for the NES CPU bus ($4014).
//  - Snoops CPU writes to TRIGGER_ADDR and latches the written value as source page P.
//  - Halts the CPU, then copies 256 bytes from $PP00-$PPFF to OAM_DATA_ADDR ($2004) as alternating read/write cycles.
//  - Acts as a second bus master, muxed ahead of the CPU in the top-level CPU bus selection.

---
 rtl/nes_bus_pkg.sv | 20 ++
 rtl/oam_dma_controller.sv | 110 +++++++++++
 tb/tb_oam_dma_controller.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nes_bus_pkg.sv
// Shared CPU-bus definitions: OAM DMA state encoding and the register addresses
// that both the DMA engine and the top-level bus mux decode.
package nes_bus_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HALT,
      ALIGN,
      READ,
      WRITE
   } dma_state_t;

   localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
   localparam logic [15:0] ADDR_OAMDATA = 16'h2004;

   // The parity flop splits CPU cycles into GET (read) and PUT (write) slots.
   localparam logic PARITY_GET = 1'b0;
   localparam logic PARITY_PUT = 1'b1;

endpackage

// File: rtl/oam_dma_controller.sv
// Sprite OAM DMA engine: snoops the $4014 write, halts the CPU and copies one
// 256-byte page to $2004 as alternating GET/PUT bus cycles.
module oam_dma_controller
   import nes_bus_pkg::*;
#(
   parameter logic [15:0] TRIGGER_ADDR  = ADDR_OAMDMA,
   parameter logic [15:0] OAM_DATA_ADDR = ADDR_OAMDATA,
   parameter int          XFER_LEN      = 256
) (
   input  logic        CPU_CLK,
   input  logic        RESET_n,
   input  logic        ENABLE,
   input  logic [15:0] CPU_ADDR,
   input  logic [7:0]  CPU_DATA_OUT,
   input  logic        CPU_RW_n,
   input  logic [7:0]  DMA_DATA_IN,
   output logic        CPU_HALT,
   output logic        DMA_ACTIVE,
   output logic [15:0] DMA_ADDR,
   output logic        DMA_RW_n,
   output logic [7:0]  DMA_DATA_OUT,
   output logic        DMA_BUSY
);

   localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

   dma_state_t state_reg;
   logic [7:0] page_reg;
   logic [7:0] idx_reg;
   logic [7:0] latch_reg;
   logic       parity_reg;

   logic trigger;
   assign trigger = !CPU_RW_n && (CPU_ADDR == TRIGGER_ADDR);

   always_ff @(posedge CPU_CLK) begin
      if (!RESET_n) begin
         state_reg  <= IDLE;
         page_reg   <= 8'h00;
         idx_reg    <= 8'h00;
         latch_reg  <= 8'h00;
         parity_reg <= PARITY_GET;
      end else if (ENABLE) begin
         parity_reg <= ~parity_reg;
         case (state_reg)
            IDLE: begin
               if (trigger) begin
                  page_reg  <= CPU_DATA_OUT;
                  idx_reg   <= 8'h00;
                  state_reg <= HALT;
               end
            end
            HALT: begin
               // The next cycle's slot is the inverse of the current one.
               state_reg <= (parity_reg == PARITY_PUT) ? READ : ALIGN;
            end
            ALIGN: begin
               state_reg <= READ;
            end
            READ: begin
               latch_reg <= DMA_DATA_IN;
               state_reg <= WRITE;
            end
            WRITE: begin
               if (idx_reg == LAST_IDX) begin
                  idx_reg   <= 8'h00;
                  state_reg <= IDLE;
               end else begin
                  idx_reg   <= idx_reg + 8'h01;
                  state_reg <= READ;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   // Outputs decode registered state only, so the bus mux sees no input paths.
   always_comb begin
      CPU_HALT     = 1'b0;
      DMA_ACTIVE   = 1'b0;
      DMA_ADDR     = 16'h0000;
      DMA_RW_n     = 1'b1;
      DMA_DATA_OUT = 8'h00;
      case (state_reg)
         HALT, ALIGN: begin
            CPU_HALT = 1'b1;
         end
         READ: begin
            CPU_HALT   = 1'b1;
            DMA_ACTIVE = 1'b1;
            DMA_ADDR   = {page_reg, idx_reg};
         end
         WRITE: begin
            CPU_HALT     = 1'b1;
            DMA_ACTIVE   = 1'b1;
            DMA_ADDR     = OAM_DATA_ADDR;
            DMA_RW_n     = 1'b0;
            DMA_DATA_OUT = latch_reg;
         end
         default: begin
         end
      endcase
   end

   assign DMA_BUSY = CPU_HALT;

endmodule

// File: tb/tb_oam_dma_controller.sv
// Scoreboard bench for oam_dma_controller: a transfer-level model queues the
// expected bus cycles and halt length; a negedge monitor pops and compares.
module tb_oam_dma_controller;

   logic        CPU_CLK = 1'b0;
   logic        RESET_n;
   logic        ENABLE;
   logic [15:0] CPU_ADDR;
   logic [7:0]  CPU_DATA_OUT;
   logic        CPU_RW_n;
   logic [7:0]  DMA_DATA_IN;
   logic        CPU_HALT;
   logic        DMA_ACTIVE;
   logic [15:0] DMA_ADDR;
   logic        DMA_RW_n;
   logic [7:0]  DMA_DATA_OUT;
   logic        DMA_BUSY;

   oam_dma_controller dut (
      .CPU_CLK      (CPU_CLK),
      .RESET_n      (RESET_n),
      .ENABLE       (ENABLE),
      .CPU_ADDR     (CPU_ADDR),
      .CPU_DATA_OUT (CPU_DATA_OUT),
      .CPU_RW_n     (CPU_RW_n),
      .DMA_DATA_IN  (DMA_DATA_IN),
      .CPU_HALT     (CPU_HALT),
      .DMA_ACTIVE   (DMA_ACTIVE),
      .DMA_ADDR     (DMA_ADDR),
      .DMA_RW_n     (DMA_RW_n),
      .DMA_DATA_OUT (DMA_DATA_OUT),
      .DMA_BUSY     (DMA_BUSY)
   );

   always #5 CPU_CLK = ~CPU_CLK;

   // Memory behind the CPU bus answers within the READ cycle.
   logic [7:0] mem [0:65535];
   assign DMA_DATA_IN = mem[DMA_ADDR];

   typedef struct packed {
      logic        is_write;
      logic [15:0] addr;
      logic [7:0]  data;
   } txn_t;

   txn_t exp_q[$];
   int   len_q[$];

   int checks = 0;
   int errors = 0;

   // Model state: enabled-cycle parity and remaining halted cycles.
   bit m_parity = 1'b0;
   int remaining = 0;
   int hcount = 0;
   int last_halt_len = 0;
   int xfer_done = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   // Reference model: a transfer halts the CPU for 512 bus cycles plus one or
   // two lead-in cycles, depending on the slot the trigger lands in.
   always @(posedge CPU_CLK) begin
      if (!RESET_n) begin
         remaining = 0;
         m_parity  = 1'b0;
         exp_q.delete();
         len_q.delete();
      end else if (ENABLE) begin
         if (remaining == 0) begin
            if (!CPU_RW_n && CPU_ADDR == 16'h4014) begin
               remaining = m_parity ? 514 : 513;
               len_q.push_back(remaining);
               for (int i = 0; i < 256; i++) begin
                  exp_q.push_back({1'b0, CPU_DATA_OUT, 8'(i), 8'h00});
                  exp_q.push_back({1'b1, 16'h2004, mem[{CPU_DATA_OUT, 8'(i)}]});
               end
            end
         end else begin
            remaining--;
         end
         m_parity = !m_parity;
      end
   end

   // Monitor
   always @(negedge CPU_CLK) begin
      txn_t t;
      if (!RESET_n) begin
         hcount = 0;
      end else if (ENABLE) begin
         chk("busy_eq_halt", 32'(DMA_BUSY), 32'(CPU_HALT));
         chk("halt_vs_model", 32'(CPU_HALT), 32'(remaining > 0));
         if (CPU_HALT) begin
            hcount++;
         end else begin
            chk("idle_outputs", {DMA_ACTIVE, DMA_ADDR, DMA_RW_n, DMA_DATA_OUT},
                {1'b0, 16'h0000, 1'b1, 8'h00});
            if (hcount > 0) begin
               if (len_q.size() == 0) begin
                  chk("halt_len_unexpected", 32'(hcount), 32'h0);
               end else begin
                  chk("halt_len", 32'(hcount), 32'(len_q.pop_front()));
               end
               last_halt_len = hcount;
               xfer_done++;
               $display("transfer %0d done: halt_cycles=%0d", xfer_done, hcount);
               hcount = 0;
            end
         end
         if (DMA_ACTIVE) begin
            chk("active_implies_halt", 32'(CPU_HALT), 32'h1);
            if (exp_q.size() == 0) begin
               chk("bus_cycle_unexpected", {15'h0, DMA_RW_n, DMA_ADDR}, 32'hFFFF_FFFF);
            end else begin
               t = exp_q.pop_front();
               if (t.is_write)
                  chk("wr_cycle", {DMA_RW_n, DMA_ADDR, DMA_DATA_OUT}, {1'b0, t.addr, t.data});
               else
                  chk("rd_cycle", {DMA_RW_n, DMA_ADDR}, {1'b1, t.addr});
            end
         end
      end
   end

   // want_par: 0/1 selects the slot of the trigger cycle, 2 = any.
   task automatic trigger(input logic [15:0] addr, input logic [7:0] data, input int want_par);
      int n = 0;
      @(posedge CPU_CLK); #1;
      while (want_par != 2 && int'(m_parity) != want_par && n < 8) begin
         @(posedge CPU_CLK); #1;
         n++;
      end
      CPU_ADDR = addr; CPU_DATA_OUT = data; CPU_RW_n = 1'b0;
      @(posedge CPU_CLK); #1;
      CPU_ADDR = 16'h0000; CPU_DATA_OUT = 8'h00; CPU_RW_n = 1'b1;
   endtask

   task automatic wait_idle(input bit rnd_en);
      int n = 0;
      bit done = 1'b0;
      while (!done && n < 3000) begin
         @(posedge CPU_CLK); #1;
         ENABLE = rnd_en ? ($urandom_range(0, 7) != 0) : 1'b1;
         if (remaining == 0 && !CPU_HALT) done = 1'b1;
         n++;
      end
      ENABLE = 1'b1;
      if (!done) chk("wait_idle_timeout", 32'(n), 32'h0);
      @(negedge CPU_CLK); #1;
   endtask

   task automatic wait_read_idx(input logic [7:0] idx, output bit found);
      int n = 0;
      found = 1'b0;
      while (!found && n < 2000) begin
         @(posedge CPU_CLK); #1;
         if (DMA_ACTIVE && DMA_RW_n && DMA_ADDR[7:0] == idx) found = 1'b1;
         n++;
      end
      if (!found) chk("wait_read_timeout", {24'h0, idx}, 32'hFFFF_FFFF);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      logic [7:0] pg;
      int n;

      for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
      for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i);

      RESET_n = 1'b0; ENABLE = 1'b1;
      CPU_ADDR = 16'h0000; CPU_DATA_OUT = 8'h00; CPU_RW_n = 1'b1;
      repeat (3) @(posedge CPU_CLK);
      #1;
      chk("reset_outputs", {CPU_HALT, DMA_ACTIVE, DMA_ADDR, DMA_RW_n, DMA_DATA_OUT, DMA_BUSY},
          {1'b0, 1'b0, 16'h0000, 1'b1, 8'h00, 1'b0});
      RESET_n = 1'b1;
      repeat (2) @(posedge CPU_CLK);

      // 1) aligned trigger: 513 halted cycles, data 0..255
      trigger(16'h4014, 8'h02, 0);
      wait_idle(1'b0);
      chk("t1_halt_len", 32'(last_halt_len), 32'd513);

      // 2) opposite slot: ALIGN inserted
      trigger(16'h4014, 8'h02, 1);
      wait_idle(1'b0);
      chk("t2_halt_len", 32'(last_halt_len), 32'd514);

      // 3) reset at idx 0x80, then restart from page 3
      trigger(16'h4014, 8'h02, 2);
      wait_read_idx(8'h80, found);
      RESET_n = 1'b0;
      @(posedge CPU_CLK); #1;
      RESET_n = 1'b1;
      chk("t3_after_reset", {CPU_HALT, DMA_ACTIVE, DMA_RW_n}, {1'b0, 1'b0, 1'b1});
      trigger(16'h4014, 8'h03, 2);
      wait_idle(1'b0);

      // 4) ENABLE low for 10 cycles during READ idx 0x10
      pg = 8'($urandom);
      trigger(16'h4014, pg, 2);
      wait_read_idx(8'h10, found);
      ENABLE = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge CPU_CLK);
         chk("t4_frozen", {DMA_ACTIVE, DMA_RW_n, DMA_ADDR}, {1'b1, 1'b1, pg, 8'h10});
         @(posedge CPU_CLK); #1;
      end
      ENABLE = 1'b1;
      wait_idle(1'b0);
      chk("t4_halt_len", 32'(last_halt_len >= 513 && last_halt_len <= 514), 32'h1);

      // 5) page 0xFF, then non-trigger accesses
      trigger(16'h4014, 8'hFF, 2);
      wait_idle(1'b0);
      @(posedge CPU_CLK); #1;
      CPU_ADDR = 16'h4014; CPU_DATA_OUT = 8'h04; CPU_RW_n = 1'b1;
      @(posedge CPU_CLK); #1;
      CPU_ADDR = 16'h4015; CPU_RW_n = 1'b0;
      @(posedge CPU_CLK); #1;
      CPU_ADDR = 16'h0000; CPU_DATA_OUT = 8'h00; CPU_RW_n = 1'b1;
      repeat (4) @(posedge CPU_CLK);
      #1;
      chk("t5_no_trigger", {CPU_HALT, DMA_ACTIVE}, 2'b00);

      // 6) write to $4014 mid-transfer is ignored
      trigger(16'h4014, 8'h05, 2);
      repeat (100) @(posedge CPU_CLK);
      #1;
      CPU_ADDR = 16'h4014; CPU_DATA_OUT = 8'h07; CPU_RW_n = 1'b0;
      @(posedge CPU_CLK); #1;
      CPU_ADDR = 16'h0000; CPU_DATA_OUT = 8'h00; CPU_RW_n = 1'b1;
      wait_idle(1'b0);

      // Trigger coinciding with the final WRITE is ignored
      trigger(16'h4014, 8'h06, 2);
      n = 0;
      while (remaining != 1 && n < 1000) begin
         @(posedge CPU_CLK); #1;
         n++;
      end
      chk("final_write_reached", 32'(remaining), 32'd1);
      CPU_ADDR = 16'h4014; CPU_DATA_OUT = 8'h08; CPU_RW_n = 1'b0;
      @(posedge CPU_CLK); #1;
      CPU_ADDR = 16'h0000; CPU_DATA_OUT = 8'h00; CPU_RW_n = 1'b1;
      repeat (3) @(posedge CPU_CLK);
      #1;
      chk("final_write_no_retrigger", 32'(CPU_HALT), 32'h0);

      // Randomized transfers with ENABLE dropouts and stray $4014 writes
      for (int r = 0; r < 4; r++) begin
         repeat ($urandom_range(0, 5)) @(posedge CPU_CLK);
         trigger(16'h4014, 8'($urandom), 2);
         repeat ($urandom_range(10, 300)) @(posedge CPU_CLK);
         #1;
         CPU_ADDR = 16'h4014; CPU_DATA_OUT = 8'($urandom); CPU_RW_n = 1'b0;
         @(posedge CPU_CLK); #1;
         CPU_ADDR = 16'h0000; CPU_RW_n = 1'b1;
         wait_idle(1'b1);
      end

      repeat (4) @(posedge CPU_CLK);
      #1;
      chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
      chk("len_q_drained", 32'(len_q.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
